sisc_ctrl_mc: RTL and testbench

Parametrised multi-cycle control unit for the SISC processor. It owns the PC and sequences fetch/decode/execute/memory/writeback. Beyond the original ALU-only control path, it adds loads, stores, conditional and relative branches, and HALT. It also handles variable-latency memory through a ready handshake, with a timeout fault. It sits between instruction/data memory, IR, register file, ALU and status register.

---
 rtl/sisc_ctrl_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_mc - multi-cycle control unit for the SISC processor.
//
// Owns the program counter. Steps each instruction through FETCH, DECODE,
// EXECUTE, MEM and WRITEBACK, and drives the strobes for instruction/data
// memory, IR, register file, ALU and status register. Memory accesses use a
// ready handshake. A wait counter turns a stalled access into a permanent
// FAULT. HALT and FAULT are left only by reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   ir         current instruction: [31:28] opcode, [27:24] func/cond mask,
//              [23:20] rd, [19:16] rs, [15:12] rt, [15:0] imm
//   stat       registered status flags {C,V,N,Z}
//   mem_ready  completion handshake from instruction/data memory
//   pc         program counter
//   imem_re    instruction read request
//   ir_load    IR load strobe (asserted while fetching and mem_ready is high)
//   rf_we      register file write enable
//   wb_sel     writeback source: 0 = ALU, 1 = data memory
//   alu_op     ALU function
//   alu_imm    ALU operand B = sign-extended imm
//   stat_en    status register load enable
//   dmem_re    data read request
//   dmem_we    data write request
//   halted     processor stopped (HALT or FAULT)
//   fault      memory timeout occurred
// -----------------------------------------------------------------------------
module sisc_ctrl_mc #(
  parameter int PC_W        = 16,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ir,
  input  logic [3:0]      stat,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic            imem_re,
  output logic            ir_load,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [3:0]      alu_op,
  output logic            alu_imm,
  output logic            stat_en,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [3:0] OP_ALU_R = 4'h1;
  localparam logic [3:0] OP_ALU_I = 4'h2;
  localparam logic [3:0] OP_LOD   = 4'h3;
  localparam logic [3:0] OP_STR   = 4'h4;
  localparam logic [3:0] OP_BRA   = 4'h5;
  localparam logic [3:0] OP_BRR   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] ALU_ADD  = 4'h1;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;

  logic [3:0]           opcode;
  logic [3:0]           func;
  logic                 is_lod;
  logic                 is_alu;
  logic [PC_W-1:0]      imm_pc;
  logic [TIMEOUT_W-1:0] wait_inc;
  logic                 timeout_hit;
  logic                 unused_ir;

  assign opcode = ir[31:28];
  assign func   = ir[27:24];
  assign is_lod = (opcode == OP_LOD);
  assign is_alu = (opcode == OP_ALU_R) || (opcode == OP_ALU_I);
  assign imm_pc = PC_W'($signed(ir[15:0]));
  // Register fields are consumed by the datapath, not by this controller.
  assign unused_ir = ^ir[23:16];

  // Saturate so a disabled timeout can never wrap into a spurious match.
  assign wait_inc    = (&wait_q) ? wait_q : wait_q + TIMEOUT_W'(1);
  // Fires on the not-ready cycle that would bring the count to the limit;
  // a ready on that same cycle takes the normal path instead.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_W'(MEM_TIMEOUT));

  assign pc = pc_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
      pc_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    imem_re = 1'b0;
    ir_load = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    alu_op  = 4'h0;
    alu_imm = 1'b0;
    stat_en = 1'b0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end

      S_FETCH: begin
        imem_re = 1'b1;
        ir_load = mem_ready;
        if (mem_ready) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_DECODE: begin
        // Branch targets use the pc already advanced during FETCH.
        if (opcode == OP_BRA && |(stat & func)) begin
          pc_d = ir[PC_W-1:0];
        end else if (opcode == OP_BRR) begin
          pc_d = pc_q + imm_pc;
        end
        if (is_alu || opcode == OP_LOD || opcode == OP_STR) begin
          state_d = S_EXECUTE;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_EXECUTE: begin
        if (is_alu) begin
          alu_op  = func;
          alu_imm = (opcode == OP_ALU_I);
          stat_en = 1'b1;
          state_d = S_WRITEBACK;
        end else begin
          // Loads and stores: ALU forms the address rs + imm.
          alu_op  = ALU_ADD;
          alu_imm = 1'b1;
          state_d = S_MEM;
          wait_d  = '0;
        end
      end

      S_MEM: begin
        alu_op  = ALU_ADD;
        alu_imm = 1'b1;
        dmem_re = is_lod;
        dmem_we = (opcode == OP_STR);
        if (mem_ready) begin
          state_d = is_lod ? S_WRITEBACK : S_FETCH;
          wait_d  = '0;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WRITEBACK: begin
        rf_we   = 1'b1;
        wb_sel  = is_lod;
        alu_op  = is_lod ? ALU_ADD : func;
        alu_imm = is_lod || (opcode == OP_ALU_I);
        state_d = S_FETCH;
        wait_d  = '0;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_sisc_ctrl_mc - directed bench for sisc_ctrl_mc.
// Three instances share the inputs: default parameters, MEM_TIMEOUT = 0
// (timeout disabled) and PC_W = 4 (pc wrap). Outputs are sampled 1 ns after
// the rising edge, and inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_sisc_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic [3:0]  stat;
  logic        mem_ready;

  logic [15:0] pc;
  logic        imem_re, ir_load, rf_we, wb_sel, alu_imm, stat_en;
  logic        dmem_re, dmem_we, halted, fault;
  logic [3:0]  alu_op;

  logic [15:0] nt_pc;
  logic        nt_imem_re, nt_ir_load, nt_rf_we, nt_wb_sel, nt_alu_imm, nt_stat_en;
  logic        nt_dmem_re, nt_dmem_we, nt_halted, nt_fault;
  logic [3:0]  nt_alu_op;

  logic [3:0]  p4_pc;
  logic        p4_imem_re, p4_ir_load, p4_rf_we, p4_wb_sel, p4_alu_imm, p4_stat_en;
  logic        p4_dmem_re, p4_dmem_we, p4_halted, p4_fault;
  logic [3:0]  p4_alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  always #5 clk = ~clk;

  sisc_ctrl_mc dut (
    .clk(clk), .rst(rst), .ir(ir), .stat(stat), .mem_ready(mem_ready),
    .pc(pc), .imem_re(imem_re), .ir_load(ir_load), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_op(alu_op), .alu_imm(alu_imm), .stat_en(stat_en),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted), .fault(fault)
  );

  sisc_ctrl_mc #(.MEM_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .ir(ir), .stat(stat), .mem_ready(mem_ready),
    .pc(nt_pc), .imem_re(nt_imem_re), .ir_load(nt_ir_load), .rf_we(nt_rf_we),
    .wb_sel(nt_wb_sel), .alu_op(nt_alu_op), .alu_imm(nt_alu_imm),
    .stat_en(nt_stat_en), .dmem_re(nt_dmem_re), .dmem_we(nt_dmem_we),
    .halted(nt_halted), .fault(nt_fault)
  );

  sisc_ctrl_mc #(.PC_W(4)) dut_p4 (
    .clk(clk), .rst(rst), .ir(ir), .stat(stat), .mem_ready(mem_ready),
    .pc(p4_pc), .imem_re(p4_imem_re), .ir_load(p4_ir_load), .rf_we(p4_rf_we),
    .wb_sel(p4_wb_sel), .alu_op(p4_alu_op), .alu_imm(p4_alu_imm),
    .stat_en(p4_stat_en), .dmem_re(p4_dmem_re), .dmem_we(p4_dmem_we),
    .halted(p4_halted), .fault(p4_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset mid-cycle, then release it 1 ns after an edge (DUT in START).
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ir        = 32'h0;
    stat      = 4'h0;
    mem_ready = 1'b1;
    #1;
    check("reset_pc",      pc,      0);
    check("reset_imem_re", imem_re, 0);
    check("reset_ir_load", ir_load, 0);
    check("reset_halted",  halted,  0);
    check("reset_fault",   fault,   0);

    // ---- ADI through the ALU path -------------------------------------
    ir = 32'h2110_0001;
    step();
    rst = 1'b0;                     // START
    step();                         // FETCH
    check("adi_fetch_imem_re", imem_re, 1);
    check("adi_fetch_ir_load", ir_load, 1);
    check("adi_fetch_pc",      pc,      16'h0000);
    step();                         // DECODE
    check("adi_decode_pc",      pc,      16'h0001);
    check("adi_decode_imem_re", imem_re, 0);
    check("adi_decode_stat_en", stat_en, 0);
    step();                         // EXECUTE
    check("adi_exec_alu_op",  alu_op,  4'h1);
    check("adi_exec_alu_imm", alu_imm, 1);
    check("adi_exec_stat_en", stat_en, 1);
    check("adi_exec_rf_we",   rf_we,   0);
    step();                         // WRITEBACK
    check("adi_wb_rf_we",   rf_we,   1);
    check("adi_wb_wb_sel",  wb_sel,  0);
    check("adi_wb_alu_op",  alu_op,  4'h1);
    check("adi_wb_stat_en", stat_en, 0);
    step();                         // FETCH, 4 cycles after the first one
    check("adi_next_fetch", imem_re, 1);
    check("adi_next_pc",    pc,      16'h0001);

    // ---- BRA taken / not taken, BRR backwards --------------------------
    ir   = 32'h5A00_0010;
    stat = 4'b1010;
    step(2);
    check("bra_taken_pc", pc, 16'h0010);
    stat = 4'b0101;
    step(2);
    check("bra_not_taken_pc", pc, 16'h0011);
    ir   = 32'h5F00_0005;
    stat = 4'b1111;
    step(2);
    check("bra_to_5_pc", pc, 16'h0005);
    ir = 32'h6000_FFFE;
    step();
    check("brr_decode_pc", pc, 16'h0006);
    step();
    check("brr_target_pc", pc, 16'h0004);
    check("brr_fetch",     imem_re, 1);

    // ---- LOD with 3 wait cycles in MEM ---------------------------------
    ir = 32'h3120_0004;
    step(2);                        // DECODE, EXECUTE
    check("lod_exec_alu_op",  alu_op,  4'h1);
    check("lod_exec_stat_en", stat_en, 0);
    mem_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dmem_re === 1'b1) cnt++;
      if (i == 3) mem_ready = 1'b1;
    end
    check("lod_mem_dmem_we", dmem_we, 0);
    check("lod_mem_alu_op",  alu_op,  4'h1);
    check("lod_dmem_re_cycles", cnt, 4);
    step();                         // WRITEBACK
    check("lod_wb_rf_we",   rf_we,   1);
    check("lod_wb_wb_sel",  wb_sel,  1);
    check("lod_wb_dmem_re", dmem_re, 0);
    step();
    check("lod_after_rf_we", rf_we, 0);
    check("lod_after_pc",    pc,    16'h0005);

    // ---- STR with zero-wait memory -------------------------------------
    ir = 32'h4120_0004;
    step(2);                        // DECODE, EXECUTE
    check("str_exec_stat_en", stat_en, 0);
    step();                         // MEM
    check("str_mem_dmem_we", dmem_we, 1);
    check("str_mem_dmem_re", dmem_re, 0);
    check("str_mem_rf_we",   rf_we,   0);
    step();                         // back to FETCH
    check("str_fetch_dmem_we", dmem_we, 0);
    check("str_fetch_imem_re", imem_re, 1);
    check("str_fetch_pc",      pc,      16'h0006);

    // ---- fetch timeout: 15 not-ready cycles -> FAULT -------------------
    ir        = 32'h0;
    mem_ready = 1'b0;               // first not-ready cycle in progress
    step(14);                       // 15th not-ready cycle
    check("timeout_15th_fault", fault,   0);
    check("timeout_15th_fetch", imem_re, 1);
    step();
    check("timeout_fault",   fault,   1);
    check("timeout_halted",  halted,  1);
    check("timeout_pc",      pc,      16'h0006);
    check("timeout_imem_re", imem_re, 0);
    mem_ready = 1'b1;
    step(3);
    check("fault_sticky", fault, 1);
    check("fault_pc",     pc,    16'h0006);

    // ---- ready on the 15th wait cycle wins -----------------------------
    mem_ready = 1'b0;
    do_reset();
    step();                         // FETCH, not-ready cycle 1
    step(14);                       // cycle 15
    mem_ready = 1'b1;
    #1;
    check("edge_ready_ir_load", ir_load, 1);
    step();
    check("edge_ready_fault", fault, 0);
    check("edge_ready_pc",    pc,    16'h0001);

    // ---- MEM_TIMEOUT = 0 never faults ----------------------------------
    mem_ready = 1'b0;
    do_reset();
    step(40);
    check("nt_fault",    nt_fault,   0);
    check("nt_imem_re",  nt_imem_re, 1);
    check("def_faulted", fault,      1);

    // ---- HALT ------------------------------------------------------------
    mem_ready = 1'b1;
    ir        = 32'hF000_0000;
    do_reset();
    step(2);                        // FETCH, DECODE
    check("halt_decode_halted", halted, 0);
    step();
    check("halt_halted", halted, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_re !== 1'b0) cnt++;
    end
    check("halt_imem_re_cycles", cnt,    0);
    check("halt_still_halted",   halted, 1);
    check("halt_pc",             pc,     16'h0001);
    check("halt_fault",          fault,  0);

    // ---- PC_W = 4 wrap on NOP at pc = F --------------------------------
    ir = 32'h0;
    do_reset();
    step();                         // FETCH at pc 0
    step(30);                       // 15 NOPs
    check("p4_pc_f",    p4_pc,      4'hF);
    check("p4_fetch",   p4_imem_re, 1);
    step();
    check("p4_pc_wrap", p4_pc,      4'h0);

    // ---- reset in the middle of a LOD MEM phase ------------------------
    ir = 32'h3120_0004;
    do_reset();
    step(3);                        // FETCH, DECODE, EXECUTE
    mem_ready = 1'b0;
    step();                         // MEM
    check("mid_mem_dmem_re", dmem_re, 1);
    check("mid_mem_pc",      pc,      16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dmem_re", dmem_re, 0);
    check("async_rst_pc",      pc,      16'h0000);
    check("async_rst_halted",  halted,  0);
    check("async_rst_fault",   fault,   0);
    step();
    rst       = 1'b0;
    mem_ready = 1'b1;
    check("post_rst_start_imem_re", imem_re, 0);
    step();
    check("post_rst_fetch_imem_re", imem_re, 1);
    check("post_rst_fetch_pc",      pc,      16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
